// File: rtl/watch_time_setter_if.sv
// Bundle of the time-edit stage signals: one-second tick, debounced
// buttons, the running date/time from the counter, and the load path
// back into the counter together with the display status.
interface watch_time_setter_if;
    logic        clk1sec;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;
    logic [13:0] cur_year;
    logic [7:0]  cur_month;
    logic [7:0]  cur_day;
    logic [7:0]  cur_hour;
    logic [7:0]  cur_min;
    logic [7:0]  cur_sec;
    logic [53:0] transfer_time;
    logic        set_time;
    logic        edit_active;
    logic [2:0]  edit_field;
    logic        blink;

    // Stimulus side: drives buttons, tick and running time; observes the load path.
    modport master (
        output clk1sec, btn_mode, btn_next, btn_up, btn_down,
        output cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        input  transfer_time, set_time, edit_active, edit_field, blink
    );

    // Edit stage side.
    modport slave (
        input  clk1sec, btn_mode, btn_next, btn_up, btn_down,
        input  cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        output transfer_time, set_time, edit_active, edit_field, blink
    );
endinterface

// File: rtl/watch_time_setter.sv
// Watch time-edit stage. A mode press snapshots the running date/time,
// next/up/down step through and modify the fields with wrap-around, and a
// second mode press commits the edited value to the counter with a single
// set_time strobe. The day field is clamped to the month length (with
// Gregorian leap years) whenever year or month changes, so the edit
// registers never hold an impossible date. Inactivity in EDIT for
// TIMEOUT_SEC seconds abandons the edit without loading the counter.
module watch_time_setter #(
    parameter int TIMEOUT_SEC = 30,
    parameter int YEAR_MIN    = 1,
    parameter int YEAR_MAX    = 9999
) (
    input logic                clk,
    input logic                rst,
    watch_time_setter_if.slave bus
);

    localparam logic [13:0] YEAR_MIN_C = 14'(YEAR_MIN);
    localparam logic [13:0] YEAR_MAX_C = 14'(YEAR_MAX);
    localparam logic [7:0]  TMO_LAST_C = 8'(TIMEOUT_SEC - 1);

    // Power-on edit value: 2022/06/09 11:30:30.
    localparam logic [13:0] RST_YEAR_C  = 14'd2022;
    localparam logic [7:0]  RST_MONTH_C = 8'd6;
    localparam logic [7:0]  RST_DAY_C   = 8'd9;
    localparam logic [7:0]  RST_HOUR_C  = 8'd11;
    localparam logic [7:0]  RST_MIN_C   = 8'd30;
    localparam logic [7:0]  RST_SEC_C   = 8'd30;

    localparam logic [2:0] FLD_YEAR_C  = 3'd0;
    localparam logic [2:0] FLD_MONTH_C = 3'd1;
    localparam logic [2:0] FLD_DAY_C   = 3'd2;
    localparam logic [2:0] FLD_HOUR_C  = 3'd3;
    localparam logic [2:0] FLD_MIN_C   = 3'd4;
    localparam logic [2:0] FLD_SEC_C   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Gregorian leap-year test on the full 14-bit year.
    function automatic logic is_leap(input logic [13:0] year);
        logic div4;
        logic div100;
        logic div400;
        div4   = ((year % 14'd4)   == 14'd0);
        div100 = ((year % 14'd100) == 14'd0);
        div400 = ((year % 14'd400) == 14'd0);
        return (div4 && !div100) || div400;
    endfunction

    // Number of days in the given month of the given year.
    function automatic logic [7:0] days_in_month(input logic [13:0] year,
                                                 input logic [7:0]  month);
        logic [7:0] days;
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: days = 8'd30;
            8'd2:                    days = is_leap(year) ? 8'd29 : 8'd28;
            default:                 days = 8'd31;
        endcase
        return days;
    endfunction

    // One wrapping step of an 8-bit field inside lo..hi. Out-of-range
    // inputs are pulled back into range rather than stepped further away.
    function automatic logic [7:0] step8(input logic [7:0] v,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi,
                                         input logic       up);
        logic [7:0] r;
        if (up) begin
            r = ((v >= hi) || (v < lo)) ? lo : v + 8'd1;
        end else begin
            r = ((v <= lo) || (v > hi)) ? hi : v - 8'd1;
        end
        return r;
    endfunction

    // One wrapping step of the 14-bit year inside lo..hi.
    function automatic logic [13:0] step14(input logic [13:0] v,
                                           input logic [13:0] lo,
                                           input logic [13:0] hi,
                                           input logic        up);
        logic [13:0] r;
        if (up) begin
            r = ((v >= hi) || (v < lo)) ? lo : v + 14'd1;
        end else begin
            r = ((v <= lo) || (v > hi)) ? hi : v - 14'd1;
        end
        return r;
    endfunction

    state_t      state_r,  state_s;
    logic [13:0] year_r,   year_s;
    logic [7:0]  month_r,  month_s;
    logic [7:0]  day_r,    day_s;
    logic [7:0]  hour_r,   hour_s;
    logic [7:0]  min_r,    min_s;
    logic [7:0]  sec_r,    sec_s;
    logic [2:0]  field_r,  field_s;
    logic        blink_r,  blink_s;
    logic [7:0]  tmo_r,    tmo_s;
    logic        set_time_r;
    logic        edit_active_r;

    logic        load_s;        // snapshot cur_* into the edit registers
    logic        edit_s;        // apply exactly one up or down step
    logic        up_only_s;
    logic [7:0]  day_step_s;
    logic [7:0]  maxd_cur_s;
    logic [7:0]  maxd_new_s;
    logic        clamp_s;

    assign up_only_s = bus.btn_up & ~bus.btn_down;

    // Next state, field selection, blink phase and inactivity counter.
    always_comb begin
        state_s = state_r;
        field_s = field_r;
        blink_s = blink_r;
        tmo_s   = tmo_r;
        load_s  = 1'b0;
        edit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                blink_s = 1'b0;
                tmo_s   = 8'd0;
                if (bus.btn_mode) begin
                    state_s = ST_EDIT;
                    load_s  = 1'b1;
                    field_s = FLD_YEAR_C;
                    blink_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EDIT: begin
                if (bus.btn_mode) begin
                    state_s = ST_COMMIT;
                    blink_s = 1'b0;
                    tmo_s   = 8'd0;
                end else if (bus.btn_next) begin
                    field_s = (field_r >= FLD_SEC_C) ? FLD_YEAR_C : field_r + 3'd1;
                    blink_s = 1'b1;
                    tmo_s   = 8'd0;
                end else if (bus.btn_up | bus.btn_down) begin
                    // Both together is activity without a value change.
                    edit_s  = bus.btn_up ^ bus.btn_down;
                    blink_s = 1'b1;
                    tmo_s   = 8'd0;
                end else if (bus.clk1sec) begin
                    if (tmo_r >= TMO_LAST_C) begin
                        state_s = ST_IDLE;
                        blink_s = 1'b0;
                        tmo_s   = 8'd0;
                    end else begin
                        blink_s = ~blink_r;
                        tmo_s   = tmo_r + 8'd1;
                    end
                end else begin
                    state_s = ST_EDIT;
                end
            end
            ST_COMMIT: begin
                state_s = ST_IDLE;
                blink_s = 1'b0;
                tmo_s   = 8'd0;
            end
            default: begin
                state_s = ST_IDLE;
                field_s = FLD_YEAR_C;
                blink_s = 1'b0;
                tmo_s   = 8'd0;
            end
        endcase
    end

    // Field arithmetic: snapshot, wrapping step, then day clamp to the new month length.
    always_comb begin
        year_s     = year_r;
        month_s    = month_r;
        day_step_s = day_r;
        hour_s     = hour_r;
        min_s      = min_r;
        sec_s      = sec_r;
        maxd_cur_s = days_in_month(year_r, month_r);
        if (load_s) begin
            year_s     = bus.cur_year;
            month_s    = bus.cur_month;
            day_step_s = bus.cur_day;
            hour_s     = bus.cur_hour;
            min_s      = bus.cur_min;
            sec_s      = bus.cur_sec;
        end else if (edit_s) begin
            case (field_r)
                FLD_YEAR_C:  year_s     = step14(year_r, YEAR_MIN_C, YEAR_MAX_C, up_only_s);
                FLD_MONTH_C: month_s    = step8(month_r, 8'd1, 8'd12, up_only_s);
                FLD_DAY_C:   day_step_s = step8(day_r, 8'd1, maxd_cur_s, up_only_s);
                FLD_HOUR_C:  hour_s     = step8(hour_r, 8'd0, 8'd23, up_only_s);
                FLD_MIN_C:   min_s      = step8(min_r, 8'd0, 8'd59, up_only_s);
                FLD_SEC_C:   sec_s      = step8(sec_r, 8'd0, 8'd59, up_only_s);
                default:     year_s     = year_r;
            endcase
        end else begin
            year_s = year_r;
        end
        // Clamp lands in the same cycle as the year/month change.
        maxd_new_s = days_in_month(year_s, month_s);
        clamp_s    = edit_s && ((field_r == FLD_YEAR_C) || (field_r == FLD_MONTH_C))
                     && (day_step_s > maxd_new_s);
        if (clamp_s) begin
            day_s = maxd_new_s;
        end else begin
            day_s = day_step_s;
        end
    end

    // State, edit registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            year_r        <= RST_YEAR_C;
            month_r       <= RST_MONTH_C;
            day_r         <= RST_DAY_C;
            hour_r        <= RST_HOUR_C;
            min_r         <= RST_MIN_C;
            sec_r         <= RST_SEC_C;
            field_r       <= FLD_YEAR_C;
            blink_r       <= 1'b0;
            tmo_r         <= 8'd0;
            set_time_r    <= 1'b0;
            edit_active_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            year_r        <= year_s;
            month_r       <= month_s;
            day_r         <= day_s;
            hour_r        <= hour_s;
            min_r         <= min_s;
            sec_r         <= sec_s;
            field_r       <= field_s;
            blink_r       <= blink_s;
            tmo_r         <= tmo_s;
            set_time_r    <= (state_s == ST_COMMIT);
            edit_active_r <= (state_s == ST_EDIT);
        end
    end

    assign bus.transfer_time = {year_r, month_r, day_r, hour_r, min_r, sec_r};
    assign bus.set_time      = set_time_r;
    assign bus.edit_active   = edit_active_r;
    assign bus.edit_field    = field_r;
    assign bus.blink         = blink_r;

endmodule

// File: tb/tb_watch_time_setter.sv
// Bench for watch_time_setter: directed scenarios followed by random
// button/tick traffic, every cycle compared against a calendar-level model.
module tb_watch_time_setter;

    localparam int TIMEOUT_SEC = 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    watch_time_setter_if ifc ();

    watch_time_setter #(
        .TIMEOUT_SEC (TIMEOUT_SEC),
        .YEAR_MIN    (1),
        .YEAR_MAX    (9999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int errors = 0;
    int checks = 0;

    // Calendar-level reference state
    int m_year, m_month, m_day, m_hour, m_min, m_sec;
    int m_field, m_tmo;
    bit m_edit, m_commit, m_blink;

    function automatic int mdays(input int y, input int mo);
        int tbl [12];
        bit leap;
        tbl  = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (mo == 2 && leap) return 29;
        return tbl[mo - 1];
    endfunction

    function automatic int wrapv(input int v, input int lo, input int hi, input int delta);
        int span;
        span = hi - lo + 1;
        return lo + ((v - lo + delta + span) % span);
    endfunction

    function automatic logic [53:0] pack(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
        return {14'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic model_reset();
        m_year = 2022; m_month = 6; m_day = 9;
        m_hour = 11;   m_min = 30;  m_sec = 30;
        m_field = 0; m_tmo = 0;
        m_edit = 1'b0; m_commit = 1'b0; m_blink = 1'b0;
    endtask

    task automatic model_step(input bit mode, input bit next, input bit up,
                              input bit down, input bit tick);
        int d;
        if (m_commit) begin
            m_commit = 1'b0;
            m_blink  = 1'b0;
        end else if (!m_edit) begin
            if (mode) begin
                m_year  = int'(ifc.cur_year);  m_month = int'(ifc.cur_month);
                m_day   = int'(ifc.cur_day);   m_hour  = int'(ifc.cur_hour);
                m_min   = int'(ifc.cur_min);   m_sec   = int'(ifc.cur_sec);
                m_edit  = 1'b1; m_field = 0; m_blink = 1'b1; m_tmo = 0;
            end
        end else if (mode || next || up || down) begin
            m_tmo   = 0;
            m_blink = 1'b1;
            if (mode) begin
                m_edit = 1'b0; m_commit = 1'b1; m_blink = 1'b0;
            end else if (next) begin
                m_field = (m_field + 1) % 6;
            end else if (up != down) begin
                d = up ? 1 : -1;
                case (m_field)
                    0: m_year  = wrapv(m_year, 1, 9999, d);
                    1: m_month = wrapv(m_month, 1, 12, d);
                    2: m_day   = wrapv(m_day, 1, mdays(m_year, m_month), d);
                    3: m_hour  = wrapv(m_hour, 0, 23, d);
                    4: m_min   = wrapv(m_min, 0, 59, d);
                    default: m_sec = wrapv(m_sec, 0, 59, d);
                endcase
                if (m_field <= 1 && m_day > mdays(m_year, m_month))
                    m_day = mdays(m_year, m_month);
            end
        end else if (tick) begin
            m_tmo++;
            m_blink = !m_blink;
            if (m_tmo == TIMEOUT_SEC) begin
                m_edit = 1'b0; m_blink = 1'b0; m_tmo = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/xfer"}, 64'(ifc.transfer_time),
            64'(pack(m_year, m_month, m_day, m_hour, m_min, m_sec)));
        chk({tag, "/set"},   64'(ifc.set_time),    64'(m_commit));
        chk({tag, "/edit"},  64'(ifc.edit_active), 64'(m_edit));
        chk({tag, "/field"}, 64'(ifc.edit_field),  64'(m_field));
        chk({tag, "/blink"}, 64'(ifc.blink),       64'(m_blink));
    endtask

    task automatic set_cur(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
        ifc.cur_year = 14'(y); ifc.cur_month = 8'(mo); ifc.cur_day = 8'(d);
        ifc.cur_hour = 8'(h);  ifc.cur_min   = 8'(mi); ifc.cur_sec = 8'(s);
    endtask

    // One clock: drive pulses, advance model, sample 1 time unit after the edge.
    task automatic cyc(input string tag, input bit mode, input bit next, input bit up,
                       input bit down, input bit tick);
        ifc.btn_mode = mode; ifc.btn_next = next; ifc.btn_up = up;
        ifc.btn_down = down; ifc.clk1sec = tick;
        model_step(mode, next, up, down, tick);
        @(posedge clk);
        #1;
        ifc.btn_mode = 1'b0; ifc.btn_next = 1'b0; ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0; ifc.clk1sec = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int yrs [4];
        int exp_days [4];
        int y, mo;
        yrs      = '{2024, 2023, 2000, 1900};
        exp_days = '{29, 28, 29, 28};

        rst = 1'b1;
        ifc.btn_mode = 1'b0; ifc.btn_next = 1'b0; ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0; ifc.clk1sec = 1'b0;
        set_cur(2001, 3, 4, 5, 6, 7);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_xfer_const", 64'(ifc.transfer_time), 64'(pack(2022, 6, 9, 11, 30, 30)));
        @(negedge clk);
        rst = 1'b0;

        // Month change to February clamps day 31 according to leap rules
        for (int i = 0; i < 4; i++) begin
            set_cur(yrs[i], 1, 31, 10, 0, 0);
            cyc("clamp_enter", 1, 0, 0, 0, 0);
            cyc("clamp_next",  0, 1, 0, 0, 0);
            cyc("clamp_up",    0, 0, 1, 0, 0);
            chk("clamp_day", 64'(ifc.transfer_time[31:24]), 64'(exp_days[i]));
            cyc("clamp_commit", 1, 0, 0, 0, 0);
            chk("commit_strobe", 64'(ifc.set_time), 64'd1);
            chk("commit_xfer", 64'(ifc.transfer_time),
                64'(pack(yrs[i], 2, exp_days[i], 10, 0, 0)));
            cyc("clamp_idle", 0, 0, 0, 0, 0);
            chk("strobe_one_cycle", 64'(ifc.set_time), 64'd0);
        end

        // Wrap at field boundaries
        set_cur(9999, 12, 31, 23, 59, 0);
        cyc("wrap_enter", 1, 0, 0, 0, 0);
        cyc("wrap_year_up", 0, 0, 1, 0, 0);
        chk("year_9999_up", 64'(ifc.transfer_time[53:40]), 64'd1);
        cyc("wrap_year_dn", 0, 0, 0, 1, 0);
        chk("year_1_down", 64'(ifc.transfer_time[53:40]), 64'd9999);
        cyc("wrap_next", 0, 1, 0, 0, 0);
        cyc("wrap_month_up", 0, 0, 1, 0, 0);
        chk("month_12_up", 64'(ifc.transfer_time[39:32]), 64'd1);
        cyc("wrap_next", 0, 1, 0, 0, 0);
        cyc("wrap_next", 0, 1, 0, 0, 0);
        cyc("wrap_hour_up", 0, 0, 1, 0, 0);
        chk("hour_23_up", 64'(ifc.transfer_time[23:16]), 64'd0);
        cyc("wrap_next", 0, 1, 0, 0, 0);
        cyc("wrap_next", 0, 1, 0, 0, 0);
        cyc("wrap_sec_dn", 0, 0, 0, 1, 0);
        chk("sec_0_down", 64'(ifc.transfer_time[7:0]), 64'd59);
        cyc("wrap_commit", 1, 0, 0, 0, 0);
        cyc("wrap_idle", 0, 0, 0, 0, 0);

        // Inactivity timeout: 30 ticks abandon the edit without a strobe
        set_cur(2010, 5, 15, 8, 8, 8);
        cyc("tmo_enter", 1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT_SEC - 1; i++) begin
            cyc("tmo_tick", 0, 0, 0, 0, 1);
            cyc("tmo_gap",  0, 0, 0, 0, 0);
        end
        chk("tmo_still_edit", 64'(ifc.edit_active), 64'd1);
        cyc("tmo_last", 0, 0, 0, 0, 1);
        chk("tmo_exit", 64'(ifc.edit_active), 64'd0);
        chk("tmo_no_strobe", 64'(ifc.set_time), 64'd0);

        // Button on the expiring tick keeps EDIT and restarts the count
        cyc("tmo2_enter", 1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT_SEC - 1; i++) cyc("tmo2_tick", 0, 0, 0, 0, 1);
        cyc("tmo2_up_on_tick", 0, 0, 1, 0, 1);
        chk("tmo2_kept", 64'(ifc.edit_active), 64'd1);
        for (int i = 0; i < TIMEOUT_SEC - 1; i++) cyc("tmo2_tick", 0, 0, 0, 0, 1);
        chk("tmo2_restarted", 64'(ifc.edit_active), 64'd1);
        cyc("tmo2_last", 0, 0, 0, 0, 1);
        chk("tmo2_exit", 64'(ifc.edit_active), 64'd0);

        // Simultaneous buttons
        set_cur(2015, 7, 20, 12, 34, 56);
        cyc("sim_enter", 1, 0, 0, 0, 0);
        cyc("sim_updown", 0, 0, 1, 1, 0);
        chk("updown_nochange", 64'(ifc.transfer_time), 64'(pack(2015, 7, 20, 12, 34, 56)));
        for (int i = 0; i < TIMEOUT_SEC - 1; i++) cyc("sim_tick", 0, 0, 0, 0, 1);
        cyc("sim_updown_tick", 0, 0, 1, 1, 1);
        for (int i = 0; i < TIMEOUT_SEC - 1; i++) cyc("sim_tick", 0, 0, 0, 0, 1);
        chk("updown_cleared_tmo", 64'(ifc.edit_active), 64'd1);
        for (int i = 0; i < 6; i++) begin
            cyc("field_next", 0, 1, 0, 0, 0);
            chk("field_cycle", 64'(ifc.edit_field), 64'((i + 1) % 6));
        end
        cyc("sim_mode_up", 1, 0, 1, 0, 0);
        chk("mode_up_strobe", 64'(ifc.set_time), 64'd1);
        chk("mode_up_nochange", 64'(ifc.transfer_time), 64'(pack(2015, 7, 20, 12, 34, 56)));
        cyc("sim_idle", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of an edit
        set_cur(2029, 3, 3, 3, 3, 3);
        cyc("rst_enter", 1, 0, 0, 0, 0);
        cyc("rst_up", 0, 0, 1, 0, 0);
        chk("rst_pre_year", 64'(ifc.transfer_time[53:40]), 64'd2030);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        ifc.btn_mode = 1'b1;
        @(posedge clk);
        #1;
        ifc.btn_mode = 1'b0;
        chk("rst_hold_no_strobe", 64'(ifc.set_time), 64'd0);
        chk("rst_hold_xfer", 64'(ifc.transfer_time), 64'(pack(2022, 6, 9, 11, 30, 30)));
        @(negedge clk);
        rst = 1'b0;
        set_cur(2044, 8, 1, 9, 10, 11);
        cyc("rst_resnap", 1, 0, 0, 0, 0);
        chk("resnap_xfer", 64'(ifc.transfer_time), 64'(pack(2044, 8, 1, 9, 10, 11)));

        // Random traffic, biased toward year edges
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       y = 1;
                1:       y = 9999;
                default: y = int'($urandom_range(1, 9999));
            endcase
            mo = int'($urandom_range(1, 12));
            set_cur(y, mo, int'($urandom_range(1, mdays(y, mo))),
                    int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    int'($urandom_range(0, 59)));
            cyc("rand",
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_time_setter.md
Name: watch_time_setter

Overview:
- User-facing time-edit stage placed directly upstream of the watch timekeeping counter.
- On a mode press it snapshots the running date/time and lets the user step through the fields with debounced buttons.
- On commit it issues a one-cycle set_time strobe with the packed value on transfer_time, which the counter loads.
- Includes field-wise range and wrap rules, day clamping for month length and leap years, and an inactivity timeout.

Parameters:
- TIMEOUT_SEC, 30: clk1sec ticks with no button activity in EDIT before abort; legal range 1..255.
- YEAR_MIN, 1: lowest editable year.
- YEAR_MAX, 9999: highest editable year.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk1sec  in  1  one-clk-wide pulse, once per second
- btn_mode  in  1  one-clk pulse (debounced): enter edit / commit
- btn_next  in  1  one-clk pulse: advance selected field
- btn_up  in  1  one-clk pulse: increment selected field
- btn_down  in  1  one-clk pulse: decrement selected field
- cur_year  in  14  running year from counter
- cur_month, cur_day, cur_hour, cur_min, cur_sec  in  8 each  running values
- transfer_time  out  54  {year[13:0], month, day, hour, min, sec}, MSB first
- set_time  out  1  one-clk load strobe
- edit_active  out  1  high while in EDIT
- edit_field  out  3  0=year 1=month 2=day 3=hour 4=min 5=sec
- blink  out  1  display blink phase for the selected field

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All edit registers are set to 2022/06/09 11:30:30; transfer_time reflects these.
  - set_time=0, edit_active=0, edit_field=0, blink=0, timeout counter=0.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE:
  - btn_mode captures cur_* into the edit registers on that edge.
  - Next cycle: EDIT, edit_field=0, blink=1, timeout counter=0.
  - btn_next, btn_up and btn_down are ignored.
- EDIT, one action per cycle, priority btn_mode > btn_next > (btn_up xor btn_down):
  - btn_mode: go to COMMIT.
  - btn_next: edit_field advances 0→1→…→5→0.
  - btn_up and btn_down together: no change, but the action still counts as activity.
- Field ranges (up and down both wrap):
  - year: YEAR_MIN..YEAR_MAX.
  - month: 1..12.
  - day: 1..maxd.
  - hour: 0..23.
  - min and sec: 0..59.
- maxd is computed from the edit registers:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 28 for February, or 29 if (year%4==0 && year%100!=0) || year%400==0.
- Day clamp: after any year or month change, if day > new maxd, then day = new maxd in the same cycle as the change. The registered result never holds an illegal date.
- Timeout:
  - The counter increments on clk1sec in EDIT and clears on any button pulse.
  - When it reaches TIMEOUT_SEC, go to IDLE without a strobe; edit registers are retained.
  - A button pulse in the same cycle as the expiring tick wins: it is processed and the counter clears.
- blink: toggles on each clk1sec in EDIT, is forced to 1 on any button pulse, and is 0 outside EDIT.
- COMMIT:
  - Lasts exactly one cycle; set_time=1 and transfer_time holds the edited value.
  - Next state is IDLE. Buttons are ignored in COMMIT.
- transfer_time is continuously driven from the edit registers. It is valid whenever set_time=1, with latency 1 clk from the committing btn_mode.
- edit_active=1 only in EDIT.
- Reset asserted mid-EDIT or in COMMIT: return to IDLE immediately with reset values. No set_time pulse may escape.
- Arithmetic:
  - The year register is 14 bits, and the leap test uses exact mod on it.
  - No field ever leaves its range, including via wrap from a minimum or maximum.

Test Plan:
- Enter edit with cur=2024/01/31 10:00:00; press btn_next once, then btn_up once (month→2); then btn_mode → day clamps to 29 in the same cycle as the month change; set_time pulses 1 clk with transfer_time=2024/02/29 10:00:00.
- Same path with year 2023 → day clamps to 28. With year 2000 → day=29. With year 1900 → day=28.
- Wrap checks:
  - year=9999, btn_up → 1; btn_down → 9999.
  - hour=23, btn_up → 0.
  - sec=0, btn_down → 59.
  - month=12, btn_up → 1.
- Timeout: enter EDIT, apply no buttons for 30 clk1sec ticks → IDLE after the 30th tick, set_time never asserted. A btn_up on the 30th tick keeps the block in EDIT.
- Simultaneous inputs:
  - btn_mode+btn_up in EDIT → COMMIT with the value unchanged.
  - btn_up+btn_down → no change, timeout counter cleared.
  - btn_next cycles edit_field 0..5 and back to 0.
- Assert rst while in EDIT with edited year 2030 → outputs at reset values immediately, edit_active=0, no set_time pulse. After release, btn_mode re-snapshots the cur_* values.
